// File: rtl/vga_pkg.sv
// Shared constants, state type and timing helpers for the VGA frame scanner.
// Default geometry is 640x480@60 built from a 160x120 image upscaled 4x.
package vga_pkg;

  localparam int DEF_IMG_W       = 160;
  localparam int DEF_IMG_H       = 120;
  localparam int DEF_SCALE_SHIFT = 2;
  localparam int DEF_RD_LAT      = 1;

  localparam int DEF_H_ACTIVE = DEF_IMG_W << DEF_SCALE_SHIFT;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = DEF_IMG_H << DEF_SCALE_SHIFT;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int CNT_W  = 10;
  localparam int ADDR_W = 8;
  localparam int RGB_W  = 3;

  typedef enum logic {IDLE, SHOW} state_t;

  function automatic int span_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int sync_start(input int active, input int fp);
    return active + fp;
  endfunction

  function automatic int sync_end(input int active, input int fp, input int sync);
    return active + fp + sync - 1;
  endfunction

  localparam int H_TOTAL      = span_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int V_TOTAL      = span_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);
  localparam int H_SYNC_START = sync_start(DEF_H_ACTIVE, DEF_H_FP);
  localparam int H_SYNC_END   = sync_end(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC);
  localparam int V_SYNC_START = sync_start(DEF_V_ACTIVE, DEF_V_FP);
  localparam int V_SYNC_END   = sync_end(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC);

endpackage

// File: rtl/vga_frame_scanner_timing_gen.sv
// Free-running horizontal/vertical counters and the raw, undelayed
// active / sync / frame-boundary decodes derived from them.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             active,
  output logic             hs_raw,
  output logic             vs_raw,
  output logic             frame_end,
  output logic             frame_start
);

  localparam int H_TOT  = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOT  = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HS_BEG = sync_start(H_ACTIVE, H_FP);
  localparam int HS_FIN = sync_end(H_ACTIVE, H_FP, H_SYNC);
  localparam int VS_BEG = sync_start(V_ACTIVE, V_FP);
  localparam int VS_FIN = sync_end(V_ACTIVE, V_FP, V_SYNC);

  logic             h_last;
  logic             v_last;
  logic [CNT_W-1:0] h_next;
  logic [CNT_W-1:0] v_next;

  assign h_last = (h_cnt == CNT_W'(H_TOT - 1));
  assign v_last = (v_cnt == CNT_W'(V_TOT - 1));

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    h_next = h_cnt + 1'b1;
    v_next = v_cnt;
    if (h_last) begin
      h_next = '0;
      v_next = v_last ? '0 : v_cnt + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments under an async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_start <= 1'b0;
    end else begin
      h_cnt       <= h_next;
      v_cnt       <= v_next;
      frame_start <= (h_next == '0) && (v_next == '0);
    end
  end

  assign active    = (h_cnt < CNT_W'(H_ACTIVE)) && (v_cnt < CNT_W'(V_ACTIVE));
  assign hs_raw    = !((h_cnt >= CNT_W'(HS_BEG)) && (h_cnt <= CNT_W'(HS_FIN)));
  assign vs_raw    = !((v_cnt >= CNT_W'(VS_BEG)) && (v_cnt <= CNT_W'(VS_FIN)));
  assign frame_end = h_last && v_last;

endmodule

// File: rtl/vga_frame_scanner.sv
// VGA scan-out of the processed image: frame-gated show/idle control, frame-buffer
// fetch with pixel replication, and a delay line keeping sync, blank and RGB aligned.
module vga_frame_scanner
  import vga_pkg::*;
#(
  parameter int SCALE_SHIFT = DEF_SCALE_SHIFT,
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_FP        = DEF_H_FP,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BP        = DEF_H_BP,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_FP        = DEF_V_FP,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BP        = DEF_V_BP,
  parameter int RD_LAT      = DEF_RD_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_vga,
  output logic              fb_rd_en,
  output logic [ADDR_W-1:0] fb_x_addr,
  output logic [ADDR_W-1:0] fb_y_addr,
  input  logic [RGB_W-1:0]  fb_din,
  output logic [RGB_W-1:0]  vga_rgb,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_blank_n,
  output logic              frame_start,
  output logic              displaying
);

  // Counter value to pins: one clock for the fetch register, RD_LAT in the
  // frame buffer, one clock for the RGB output register.
  localparam int L = RD_LAT + 2;

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             active;
  logic             hs_raw;
  logic             vs_raw;
  logic             frame_end;
  logic             qual_raw;
  state_t           state;
  state_t           state_next;
  logic [L-1:0]     hs_pipe;
  logic [L-1:0]     vs_pipe;
  logic [L-1:0]     qual_pipe;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .active      (active),
    .hs_raw      (hs_raw),
    .vs_raw      (vs_raw),
    .frame_end   (frame_end),
    .frame_start (frame_start)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // en_vga is only sampled on the last clock of a frame, so a frame is never cut.
  always_comb begin
    state_next = state;
    if (frame_end) begin
      unique case (state)
        IDLE:    if (en_vga)  state_next = SHOW;
        SHOW:    if (!en_vga) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  assign displaying = (state == SHOW);
  assign qual_raw   = active && displaying;

  // Addresses hold between reads; only the strobe drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_rd_en  <= 1'b0;
      fb_x_addr <= '0;
      fb_y_addr <= '0;
    end else begin
      fb_rd_en <= qual_raw;
      if (qual_raw) begin
        fb_x_addr <= ADDR_W'(h_cnt >> SCALE_SHIFT);
        fb_y_addr <= ADDR_W'(v_cnt >> SCALE_SHIFT);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_pipe   <= '1;
      vs_pipe   <= '1;
      qual_pipe <= '0;
      vga_rgb   <= '0;
    end else begin
      hs_pipe   <= {hs_pipe[L-2:0], hs_raw};
      vs_pipe   <= {vs_pipe[L-2:0], vs_raw};
      qual_pipe <= {qual_pipe[L-2:0], qual_raw};
      vga_rgb   <= qual_pipe[L-2] ? fb_din : '0;
    end
  end

  assign vga_hs      = hs_pipe[L-1];
  assign vga_vs      = vs_pipe[L-1];
  assign vga_blank_n = qual_pipe[L-1];

endmodule

// File: tb/tb_vga_frame_scanner.sv
// Directed bench for vga_frame_scanner on a reduced 48x23 raster (32x16 visible,
// 8x4 source image); two instances with RD_LAT = 1 and RD_LAT = 3 share stimulus.
module tb_vga_frame_scanner;

  localparam int HA = 32, HF = 4, HS = 6, HB = 6;
  localparam int VA = 16, VF = 2, VS = 2, VB = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en_vga = 1'b0;

  logic       rd1, hs1, vs1, bl1, fs1, dp1;
  logic [7:0] x1, y1;
  logic [2:0] din1, rgb1;
  logic       rd3, hs3, vs3, bl3, fs3, dp3;
  logic [7:0] x3, y3;
  logic [2:0] din3, rgb3;
  logic [2:0] p3 [3];

  int cyc;
  int passes = 0;
  int total  = 0;

  vga_frame_scanner #(
    .SCALE_SHIFT(2), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .RD_LAT(1)
  ) u1 (
    .clk(clk), .rst(rst), .en_vga(en_vga), .fb_rd_en(rd1), .fb_x_addr(x1),
    .fb_y_addr(y1), .fb_din(din1), .vga_rgb(rgb1), .vga_hs(hs1), .vga_vs(vs1),
    .vga_blank_n(bl1), .frame_start(fs1), .displaying(dp1)
  );

  vga_frame_scanner #(
    .SCALE_SHIFT(2), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .RD_LAT(3)
  ) u3 (
    .clk(clk), .rst(rst), .en_vga(en_vga), .fb_rd_en(rd3), .fb_x_addr(x3),
    .fb_y_addr(y3), .fb_din(din3), .vga_rgb(rgb3), .vga_hs(hs3), .vga_vs(vs3),
    .vga_blank_n(bl3), .frame_start(fs3), .displaying(dp3)
  );

  always #5 clk = ~clk;

  // Clocks since reset release; equals the DUT counter value h + 48*v within a frame.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Frame-buffer models returning x ^ y with one and three clocks of latency.
  always @(posedge clk) begin
    din1  <= 3'(x1 ^ y1);
    p3[0] <= 3'(x3 ^ y3);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign din3 = p3[2];

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic goto(input int n);
    do @(negedge clk); while (cyc < n);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset asserted between edges must clear outputs at once.
    en_vga = 1'b1;
    #1 rst = 1'b1;
    #1;
    check1("rst_hs", hs1, 1'b1);
    check1("rst_vs", vs1, 1'b1);
    check8("rst_rgb", {5'd0, rgb1}, 8'd0);
    check1("rst_rd_en", rd1, 1'b0);
    check1("rst_disp", dp1, 1'b0);
    check1("rst_blank", bl1, 1'b0);
    check1("rst_fs", fs1, 1'b0);
    check1("rst_hs3", hs3, 1'b1);
    #6 rst = 1'b0;

    // Frame 0 is idle (state leaves reset in IDLE); syncs still run.
    goto(38);  check1("hs1_pre", hs1, 1'b1);  check1("hs3_pre", hs3, 1'b1);
    goto(39);  check1("hs1_fall", hs1, 1'b0);
    goto(40);  check1("hs3_still_hi", hs3, 1'b1);
    goto(41);  check1("hs3_fall", hs3, 1'b0);
    goto(44);  check1("hs1_last_lo", hs1, 1'b0);
    goto(45);  check1("hs1_rise", hs1, 1'b1);
    goto(46);  check1("hs3_last_lo", hs3, 1'b0);
    goto(47);  check1("hs3_rise", hs3, 1'b1);
    goto(201); check1("idle_rd_en", rd1, 1'b0);
    goto(203); check8("idle_rgb", {5'd0, rgb1}, 8'd0);
               check1("idle_blank", bl1, 1'b0);
               check1("idle_disp", dp1, 1'b0);
    goto(866); check1("vs_pre", vs1, 1'b1);
    goto(867); check1("vs_fall", vs1, 1'b0);
    goto(962); check1("vs_last_lo", vs1, 1'b0);
    goto(963); check1("vs_rise", vs1, 1'b1);
    goto(1103); check1("fs_before", fs1, 1'b0);  check1("disp_before", dp1, 1'b0);
    goto(1104); check1("fs_pulse", fs1, 1'b1);   check1("disp_on", dp1, 1'b1);
                check1("rd_en_not_yet", rd1, 1'b0);
    goto(1105); check1("fs_after", fs1, 1'b0);   check1("first_rd", rd1, 1'b1);
                check8("first_x", x1, 8'd0);     check8("first_y", y1, 8'd0);
    goto(1106); check1("blank1_pre", bl1, 1'b0);
    goto(1107); check1("blank1_first", bl1, 1'b1);
    goto(1108); check1("blank3_pre", bl3, 1'b0);
    goto(1109); check1("blank3_first", bl3, 1'b1);

    // Frame 1, line 4: h = 8..11 maps to x = 2, y = 1 -> 3'b011.
    goto(1306); check8("pix_h7", {5'd0, rgb1}, 8'd0);
    goto(1307); check8("pix_h8", {5'd0, rgb1}, 8'd3);
    goto(1308); check8("pix_h9", {5'd0, rgb1}, 8'd3);
                check8("pix3_h7", {5'd0, rgb3}, 8'd0);
    goto(1309); check8("pix3_h8", {5'd0, rgb3}, 8'd3);
    goto(1310); check8("pix_h11", {5'd0, rgb1}, 8'd3);
    goto(1311); check8("pix_h12", {5'd0, rgb1}, 8'd2);
    goto(1330); check8("pix_h31", {5'd0, rgb1}, 8'd6);
                check1("blank_h31", bl1, 1'b1);
    goto(1331); check1("blank_h32", bl1, 1'b0);
                check8("rgb_h32", {5'd0, rgb1}, 8'd0);

    // Reset in the middle of a displayed line.
    goto(1368); check8("pre_rst_rgb", {5'd0, rgb1}, 8'd4);
                check1("pre_rst_rd", rd1, 1'b1);
    #2 rst = 1'b1;
    #1;
    check8("mid_rst_rgb", {5'd0, rgb1}, 8'd0);
    check1("mid_rst_rd", rd1, 1'b0);
    check1("mid_rst_disp", dp1, 1'b0);
    check1("mid_rst_blank", bl1, 1'b0);
    en_vga = 1'b0;
    @(negedge clk) rst = 1'b0;

    // Enable raised mid-frame: nothing until the next frame boundary.
    goto(240);  en_vga = 1'b1;
    goto(395);  check1("late_en_rd", rd1, 1'b0);
    goto(397);  check8("late_en_rgb", {5'd0, rgb1}, 8'd0);
                check1("late_en_disp", dp1, 1'b0);
    goto(1103); check1("late_en_disp_end", dp1, 1'b0);
    goto(1104); check1("late_en_disp_on", dp1, 1'b1);
                check1("fs_period_a", fs1, 1'b1);
    goto(1105); check1("late_en_first_rd", rd1, 1'b1);
                check8("late_en_x", x1, 8'd0);
                check8("late_en_y", y1, 8'd0);

    // Enable dropped mid-frame: the frame still completes.
    goto(1536); en_vga = 1'b0;
    goto(1841); check1("drop_rd", rd1, 1'b1);
                check8("drop_x", x1, 8'd4);
                check8("drop_y", y1, 8'd3);
    goto(1843); check8("drop_rgb", {5'd0, rgb1}, 8'd7);
                check1("drop_blank", bl1, 1'b1);
    goto(2207); check1("drop_disp_end", dp1, 1'b1);
                check1("fs_period_pre", fs1, 1'b0);
    goto(2208); check1("drop_disp_off", dp1, 1'b0);
                check1("fs_period_b", fs1, 1'b1);
    goto(2409); check1("off_rd", rd1, 1'b0);
                check8("off_x_hold", x1, 8'd7);
                check8("off_y_hold", y1, 8'd3);
    goto(2411); check8("off_rgb", {5'd0, rgb1}, 8'd0);
                check1("off_blank", bl1, 1'b0);
    goto(2438); check1("off_hs_pre", hs1, 1'b1);
    goto(2439); check1("off_hs_lo", hs1, 1'b0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
